board_ram_arbiter: RTL and testbench

- Shares the single 4-bit-per-cell board RAM between up to NREQ requesters: loop finder, tile placer and display scanner.
- Each requester issues one read or write at a time; the block grants round-robin, drives the RAM port and returns read data or write completion.
- An optional per-requester lock keeps ownership across long multi-access walks such as loop tracing.

---
 rtl/board_ram_arbiter_pkg.sv | 38 +++
 rtl/board_ram_arbiter_if.sv | 40 ++++
 rtl/board_ram_arbiter_rr_pick.sv | 37 +++
 rtl/board_ram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_board_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/board_ram_arbiter_pkg.sv
// Shared definitions for the board RAM arbiter and its clients.
//   - arb_state_t : arbiter FSM state encoding
//   - CELL_W      : width of one board cell (4 bits)
//   - BOARD_DEPTH : default RAM address MSB; BOARD_AW = BOARD_DEPTH+1
//   - REQ_MAX     : largest supported requester count; IDX_W indexes it
//   - rr_next     : cyclic successor of a requester index
//   - oh_to_idx   : one-hot grant to requester index
package board_ram_arbiter_pkg;

  localparam int unsigned CELL_W      = 4;
  localparam int unsigned BOARD_DEPTH = 19;
  localparam int unsigned BOARD_AW    = BOARD_DEPTH + 1;
  localparam int unsigned REQ_MAX     = 4;
  localparam int unsigned IDX_W       = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input int unsigned     nreq);
    if (32'(idx) + 32'd1 >= nreq) return '0;
    return idx + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [REQ_MAX-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < REQ_MAX; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/board_ram_arbiter_if.sv
// Requester and RAM-side bus of the board RAM arbiter.
//   Requester side : req, req_we, req_lock, req_addr, req_wdata (to arbiter)
//                    gnt, done, rdata, err (from arbiter)
//   RAM side       : mem_addr, mem_wdata, mem_we (from arbiter)
//                    mem_rdata, mem_ready (to arbiter)
// Addresses and write data are flattened per requester:
//   requester i at req_addr[i*(DEPTH+1) +: DEPTH+1], req_wdata[i*4 +: 4].
// Modports: slave = arbiter, master = requesters plus RAM.
interface board_ram_arbiter_if #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned DEPTH = board_ram_arbiter_pkg::BOARD_DEPTH
);
  import board_ram_arbiter_pkg::*;

  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            req_we;
  logic [NREQ-1:0]            req_lock;
  logic [NREQ*(DEPTH+1)-1:0]  req_addr;
  logic [NREQ*CELL_W-1:0]     req_wdata;
  logic [NREQ-1:0]            gnt;
  logic [NREQ-1:0]            done;
  logic [CELL_W-1:0]          rdata;
  logic [NREQ-1:0]            err;
  logic [DEPTH:0]             mem_addr;
  logic [CELL_W-1:0]          mem_wdata;
  logic                       mem_we;
  logic [CELL_W-1:0]          mem_rdata;
  logic                       mem_ready;

  modport slave (
    input  req, req_we, req_lock, req_addr, req_wdata, mem_rdata, mem_ready,
    output gnt, done, rdata, err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, req_we, req_lock, req_addr, req_wdata, mem_rdata, mem_ready,
    input  gnt, done, rdata, err, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/board_ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_req : request vector
//   i_ptr : index with highest priority this round (must be < NREQ)
//   o_gnt : one-hot grant of the first request at or after i_ptr, cyclic; zero if none
module rr_pick
  import board_ram_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt
);

  logic [REQ_MAX-1:0] w_req_ext;
  logic [REQ_MAX-1:0] w_gnt_ext;
  logic [IDX_W-1:0]   w_idx;
  logic               w_found;

  assign w_req_ext = REQ_MAX'(i_req);

  always_comb begin
    w_gnt_ext = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = IDX_W'((32'(i_ptr) + k) % NREQ);
      if (!w_found && w_req_ext[w_idx]) begin
        w_gnt_ext[w_idx] = 1'b1;
        w_found          = 1'b1;
      end
    end
  end

  assign o_gnt = w_gnt_ext[NREQ-1:0];

endmodule

// File: rtl/board_ram_arbiter.sv
// Board RAM arbiter: shares the single 4-bit-per-cell board RAM between
// NREQ requesters (loop finder, tile placer, display scanner).
//   clk, reset : clock, synchronous active-high reset
//   bus        : board_ram_arbiter_if slave (requester handshake + RAM port)
// One access per grant, round-robin between requesters; a requester that
// holds req_lock keeps ownership across consecutive accesses.
// Reads complete READ_LAT+1 cycles after capture; writes complete on
// mem_ready or abort with err after WR_TIMEOUT cycles.
module board_ram_arbiter
  import board_ram_arbiter_pkg::*;
#(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned DEPTH      = BOARD_DEPTH,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned WR_TIMEOUT = 255
) (
  input logic                clk,
  input logic                reset,
  board_ram_arbiter_if.slave bus
);

  localparam int unsigned AW      = DEPTH + 1;
  localparam int unsigned CNT_MAX = (WR_TIMEOUT > READ_LAT) ? WR_TIMEOUT : READ_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_t        r_state;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic [NREQ-1:0]   r_err;
  logic [CELL_W-1:0] r_rdata;
  logic [CELL_W-1:0] r_wdata;
  logic [AW-1:0]     r_addr;
  logic              r_we;
  logic              r_reserved;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;

  logic [IDX_W-1:0]  w_next_own;
  logic [IDX_W-1:0]  w_pick_ptr;
  logic [NREQ-1:0]   w_pick;
  logic [IDX_W-1:0]  w_pick_idx;
  logic [IDX_W-1:0]  w_cap_idx;
  logic [AW-1:0]     w_cap_addr;
  logic [CELL_W-1:0] w_cap_wdata;
  logic              w_cap_we;
  logic              w_req_own;
  logic              w_lock_own;

  assign w_next_own = rr_next(r_owner, NREQ);

  // When a reserved lock is dropped, the other requesters are arbitrated
  // straight away, starting after the old owner.
  assign w_pick_ptr = r_reserved ? w_next_own : r_ptr;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req (bus.req),
    .i_ptr (w_pick_ptr),
    .o_gnt (w_pick)
  );

  assign w_pick_idx = oh_to_idx(REQ_MAX'(w_pick));

  always_comb begin
    w_req_own  = 1'b0;
    w_lock_own = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_owner == IDX_W'(i)) begin
        w_req_own  = bus.req[i];
        w_lock_own = bus.req_lock[i];
      end
    end
  end

  // Fresh arbitration captures from the picked requester; a locked owner
  // re-captures its own next access.
  assign w_cap_idx = ((r_state == IDLE) && !(r_reserved && w_req_own)) ? w_pick_idx : r_owner;

  always_comb begin
    w_cap_addr  = '0;
    w_cap_wdata = '0;
    w_cap_we    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_cap_idx == IDX_W'(i)) begin
        w_cap_addr  = bus.req_addr[i*AW +: AW];
        w_cap_wdata = bus.req_wdata[i*CELL_W +: CELL_W];
        w_cap_we    = bus.req_we[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_rdata    <= '0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_reserved <= 1'b0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      unique case (r_state)
        IDLE: begin
          if (r_reserved && w_req_own) begin
            r_addr     <= w_cap_addr;
            r_wdata    <= w_cap_wdata;
            r_we       <= w_cap_we;
            r_cnt      <= '0;
            r_reserved <= 1'b0;
            r_state    <= w_cap_we ? WRITE : READ;
          end else if (!(r_reserved && w_lock_own)) begin
            if (r_reserved) begin
              r_reserved <= 1'b0;
              r_ptr      <= w_next_own;
            end
            if (|bus.req) begin
              r_gnt   <= w_pick;
              r_owner <= w_pick_idx;
              r_addr  <= w_cap_addr;
              r_wdata <= w_cap_wdata;
              r_we    <= w_cap_we;
              r_cnt   <= '0;
              r_state <= w_cap_we ? WRITE : READ;
            end else begin
              r_gnt <= '0;
            end
          end
        end

        READ: begin
          if (r_cnt == CNT_W'(READ_LAT)) begin
            r_rdata <= bus.mem_rdata;
            r_done  <= r_gnt;
            r_state <= RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        WRITE: begin
          // mem_ready wins over a coinciding timeout.
          if (bus.mem_ready) begin
            r_done  <= r_gnt;
            r_we    <= 1'b0;
            r_state <= RELEASE;
          end else if (r_cnt == CNT_W'(WR_TIMEOUT - 1)) begin
            r_done  <= r_gnt;
            r_err   <= r_gnt;
            r_we    <= 1'b0;
            r_state <= RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RELEASE: begin
          if (w_lock_own && w_req_own) begin
            r_addr  <= w_cap_addr;
            r_wdata <= w_cap_wdata;
            r_we    <= w_cap_we;
            r_cnt   <= '0;
            r_state <= w_cap_we ? WRITE : READ;
          end else if (w_lock_own) begin
            r_reserved <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_gnt   <= '0;
            r_ptr   <= w_next_own;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_we    = r_we;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter (NREQ=3, READ_LAT=2, WR_TIMEOUT=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_board_ram_arbiter;
  import board_ram_arbiter_pkg::*;

  localparam int unsigned NREQ       = 3;
  localparam int unsigned DEPTH      = 19;
  localparam int unsigned AW         = DEPTH + 1;
  localparam int unsigned READ_LAT   = 2;
  localparam int unsigned WR_TIMEOUT = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  board_ram_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH)) bus();

  board_ram_arbiter #(
    .NREQ       (NREQ),
    .DEPTH      (DEPTH),
    .READ_LAT   (READ_LAT),
    .WR_TIMEOUT (WR_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // RAM model: data for an address appears READ_LAT cycles after it is
  // presented; writes land when mem_we and mem_ready coincide.
  logic [3:0]    ram [0:255];
  logic [AW-1:0] p1, p2;

  always @(posedge clk) begin
    if (reset) begin
      ram[8'h05] <= 4'hA;
      ram[8'h33] <= 4'h6;
    end else if (bus.mem_we && bus.mem_ready) begin
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    p1 <= bus.mem_addr;
    p2 <= p1;
  end
  assign bus.mem_rdata = ram[p2[7:0]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.done == '0 && n < max_cyc);
  endtask

  task automatic set_req(input int i, input logic en, input logic we,
                         input logic [AW-1:0] addr, input logic [3:0] wd);
    bus.req[i]                = en;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = addr;
    bus.req_wdata[i*4 +: 4]   = wd;
  endtask

  logic [3:0]    fair_exp [3] = '{4'hA, 4'hF, 4'h6};
  logic [AW-1:0] lk_addr  [5] = '{20'h00033, 20'h00105, 20'h0002C, 20'h00033, 20'h00105};
  logic [3:0]    lk_exp   [5] = '{4'h6, 4'hA, 4'hF, 4'h6, 4'hA};

  initial begin
    int gnt_bad;
    int n;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ready = 1'b0;
    repeat (3) tick();

    check("rst_gnt",   32'(bus.gnt),       32'h0);
    check("rst_done",  32'(bus.done),      32'h0);
    check("rst_err",   32'(bus.err),       32'h0);
    check("rst_rdata", 32'(bus.rdata),     32'h0);
    check("rst_we",    32'(bus.mem_we),    32'h0);
    check("rst_addr",  32'(bus.mem_addr),  32'h0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    reset = 1'b0;
    tick();

    // Single read by requester 0.
    set_req(0, 1'b1, 1'b0, 20'h00105, 4'h0);
    tick();
    check("rd_gnt",   32'(bus.gnt),      32'h1);
    check("rd_maddr", 32'(bus.mem_addr), 32'h105);
    check("rd_we",    32'(bus.mem_we),   32'h0);
    check("rd_early", 32'(bus.done),     32'h0);
    tick();
    check("rd_early", 32'(bus.done),     32'h0);
    tick();
    check("rd_early", 32'(bus.done),     32'h0);
    tick();
    check("rd_done",  32'(bus.done),     32'h1);
    check("rd_data",  32'(bus.rdata),    32'hA);
    bus.req[0] = 1'b0;
    tick();
    check("rd_pulse", 32'(bus.done),     32'h0);
    check("rd_gnt0",  32'(bus.gnt),      32'h0);
    tick();
    check("rd_gnt0b", 32'(bus.gnt),      32'h0);

    // Write by requester 1, mem_ready in the 4th write cycle.
    set_req(1, 1'b1, 1'b1, 20'h0002C, 4'hF);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("wr_gnt",   32'(bus.gnt),       32'h2);
      check("wr_we",    32'(bus.mem_we),    32'h1);
      check("wr_addr",  32'(bus.mem_addr),  32'h2C);
      check("wr_wdata", 32'(bus.mem_wdata), 32'hF);
      check("wr_early", 32'(bus.done),      32'h0);
      if (c == 4) bus.mem_ready = 1'b1;
    end
    tick();
    bus.mem_ready = 1'b0;
    check("wr_done", 32'(bus.done),   32'h2);
    check("wr_err",  32'(bus.err),    32'h0);
    check("wr_weof", 32'(bus.mem_we), 32'h0);
    bus.req[1] = 1'b0;
    tick();

    // Write timeout by requester 2; second pass has mem_ready on the last cycle.
    for (int pass = 0; pass < 2; pass++) begin
      set_req(2, 1'b1, 1'b1, 20'h00040, 4'h7);
      for (int c = 1; c <= 8; c++) begin
        tick();
        check("to_we",    32'(bus.mem_we), 32'h1);
        check("to_early", 32'(bus.done),   32'h0);
        if (c == 8 && pass == 1) bus.mem_ready = 1'b1;
      end
      tick();
      bus.mem_ready = 1'b0;
      check("to_done", 32'(bus.done),   32'h4);
      check("to_err",  32'(bus.err),    (pass == 0) ? 32'h4 : 32'h0);
      check("to_weof", 32'(bus.mem_we), 32'h0);
      bus.req[2] = 1'b0;
      tick();
      check("to_errp", 32'(bus.err),    32'h0);
      check("to_gnt0", 32'(bus.gnt),    32'h0);
    end

    // Fairness: all three read continuously.
    set_req(0, 1'b1, 1'b0, 20'h00105, 4'h0);
    set_req(1, 1'b1, 1'b0, 20'h0002C, 4'h0);
    set_req(2, 1'b1, 1'b0, 20'h00033, 4'h0);
    for (int t = 0; t < 6; t++) begin
      wait_done(20);
      check("fair_done",  32'(bus.done),  32'(1 << (t % 3)));
      check("fair_gnt",   32'(bus.gnt),   32'(1 << (t % 3)));
      check("fair_rdata", 32'(bus.rdata), 32'(fair_exp[t % 3]));
    end
    bus.req = '0;
    tick();
    tick();

    // Lock: requester 2 does 5 back-to-back reads while requester 0 waits.
    bus.req_lock[2] = 1'b1;
    set_req(2, 1'b1, 1'b0, lk_addr[0], 4'h0);
    tick();
    check("lk_gnt", 32'(bus.gnt), 32'h4);
    set_req(0, 1'b1, 1'b0, 20'h00105, 4'h0);
    for (int k = 0; k < 5; k++) begin
      gnt_bad = 0;
      n = 0;
      do begin
        tick();
        n++;
        if (bus.gnt != 3'b100) gnt_bad++;
      end while (bus.done == '0 && n < 20);
      check("lk_done",  32'(bus.done),  32'h4);
      check("lk_rdata", 32'(bus.rdata), 32'(lk_exp[k]));
      check("lk_hold",  32'(gnt_bad),   32'h0);
      if (k < 4) bus.req_addr[2*AW +: AW] = lk_addr[k+1];
      else       bus.req[2] = 1'b0;
    end
    tick();
    check("lk_resv1", 32'(bus.gnt), 32'h4);
    tick();
    check("lk_resv2", 32'(bus.gnt), 32'h4);
    bus.req_lock[2] = 1'b0;
    tick();
    check("lk_handoff", 32'(bus.gnt), 32'h1);
    wait_done(20);
    check("lk_done0", 32'(bus.done),  32'h1);
    check("lk_rd0",   32'(bus.rdata), 32'hA);
    bus.req[0] = 1'b0;
    tick();

    // Reset during a write; pointer must restart at 0.
    set_req(1, 1'b1, 1'b0, 20'h0002C, 4'h0);
    wait_done(20);
    check("rs_pre_done", 32'(bus.done),  32'h2);
    check("rs_pre_rd",   32'(bus.rdata), 32'hF);
    bus.req[1] = 1'b0;
    tick();
    set_req(2, 1'b1, 1'b1, 20'h00050, 4'h9);
    tick();
    check("rs_gnt", 32'(bus.gnt),    32'h4);
    check("rs_we",  32'(bus.mem_we), 32'h1);
    tick();
    reset = 1'b1;
    tick();
    check("rs_weof",  32'(bus.mem_we),   32'h0);
    check("rs_gnt0",  32'(bus.gnt),      32'h0);
    check("rs_done",  32'(bus.done),     32'h0);
    check("rs_rdata", 32'(bus.rdata),    32'h0);
    check("rs_addr",  32'(bus.mem_addr), 32'h0);
    reset = 1'b0;
    set_req(1, 1'b1, 1'b0, 20'h0002C, 4'h0);
    set_req(2, 1'b1, 1'b0, 20'h00033, 4'h0);
    tick();
    check("rs_regrant", 32'(bus.gnt),  32'h2);
    check("rs_nodone",  32'(bus.done), 32'h0);
    wait_done(20);
    check("rs_done1", 32'(bus.done),  32'h2);
    check("rs_rd1",   32'(bus.rdata), 32'hF);
    bus.req[1] = 1'b0;
    wait_done(20);
    check("rs_done2", 32'(bus.done),  32'h4);
    check("rs_rd2",   32'(bus.rdata), 32'h6);
    bus.req[2] = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
